// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph constants, glyph table and scan state type
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic {GUARD, SHOW} scan_state_t;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// rtl/hex_glyph.sv - combinational hex nibble to active-low segment decoder
module hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  assign seg_o = glyph(value_i);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered, guard-interval multiplexed seven-segment scanner
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int GUARD_CYCLES   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] shd_dig_q, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   shd_blank_q, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   sup, an_sel;
  logic                    higher_clear;
  logic                    frame_edge, slot_end, in_guard;
  logic [3:0]              cur_dig;
  logic                    cur_dp, cur_blank, cur_sup;
  logic [6:0]              cur_glyph;
  scan_state_t             state_q, state_d;

  assign frame_edge = (cnt_q == '0) && (idx_q == '0);
  assign slot_end   = (cnt_q == CW'(REFRESH_CYCLES - 1));
  assign in_guard   = int'(cnt_q) < GUARD_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shd_dig_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
    end else begin
      if (load) begin
        shd_dig_q   <= digits_in;
        shd_dp_q    <= dp_in;
        shd_blank_q <= blank_in;
      end
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      cnt_q       <= slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) begin
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Display the frame-boundary copy on the same edge it is taken, so slot 0 is never stale
  always_comb begin
    act_dig_d   = frame_edge ? shd_dig_q   : act_dig_q;
    act_dp_d    = frame_edge ? shd_dp_q    : act_dp_q;
    act_blank_d = frame_edge ? shd_blank_q : act_blank_q;
  end

  always_comb begin
    higher_clear = 1'b1;
    sup          = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      sup[k] = lzs_en && (k != 0) && higher_clear && (act_dig_d[4*k +: 4] == 4'h0);
      higher_clear = higher_clear && ((act_dig_d[4*k +: 4] == 4'h0) || act_blank_d[k]);
    end
  end

  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig   = act_dig_d[4*k +: 4];
        cur_dp    = act_dp_d[k];
        cur_blank = act_blank_d[k];
        cur_sup   = sup[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  hex_glyph u_glyph (
    .value_i (cur_dig),
    .seg_o   (cur_glyph)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      GUARD:   if (!in_guard) state_d = SHOW;
      default: if (in_guard)  state_d = GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GUARD;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_start <= frame_edge;
      case (state_d)
        GUARD: begin
          an  <= '1;
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end
        default: begin
          an  <= an_sel;
          seg <= (cur_blank || cur_sup) ? SEG_OFF : cur_glyph;
          dp  <= cur_blank ? 1'b1 : ~cur_dp;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds double-buffered per-digit hex values, decimal points and blank flags. It scans one digit at a time at a programmable refresh rate, with a guard interval between digits to suppress ghosting, and supports optional leading-zero suppression. It sits between datapath/counter logic and the board's anode/segment pins, and replaces per-digit combinational hex decoding plus hand-built anode selection.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_CYCLES, 100000, clock cycles per digit slot, including guard (≥ 2)
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off (0 ≤ GUARD_CYCLES < REFRESH_CYCLES)
- clk  in  1  system clock; the block's only clock
- reset  in  1  synchronous, active-high
- load  in  1  single-cycle strobe; captures digits_in/dp_in/blank_in into the shadow buffer
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit k = [4k+3:4k]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = digit fully dark, including dp
- lzs_en  in  1  leading-zero suppression enable (level, sampled every cycle)
- an  out  NUM_DIGITS  anode enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a} = seg[6:0], active-low
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when a new frame begins (digit 0 slot, cycle 0)

## Operation
- **Shadow buffer:** on `load`, inputs are registered into the shadow buffer next edge.
- **Active buffer:** copies the shadow buffer at each frame boundary, the same edge that starts the digit 0 slot.
  - A frame is never torn.
  - A `load` in the same cycle as the frame boundary is not visible until the following frame.
- **Scan counter:** slot counter 0..REFRESH_CYCLES-1 and digit index 0..NUM_DIGITS-1.
  - The index increments when the slot counter wraps.
  - The index wraps NUM_DIGITS-1 → 0.
- **FSM:**
  - GUARD: slot count < GUARD_CYCLES. All anodes high, seg = 7'h7F, dp = 1.
  - SHOW: remaining cycles. `an` has only bit `idx` low.
  - Transition GUARD → SHOW at count = GUARD_CYCLES. SHOW → GUARD at slot wrap.
  - If GUARD_CYCLES = 0, GUARD never occurs.
- **Decode:** standard hex glyphs (active-low):
  - 0 → 0x40, 1 → 0x79, 2 → 0x24, 3 → 0x30, 4 → 0x19, 5 → 0x12, 6 → 0x02, 7 → 0x78
  - 8 → 0x00, 9 → 0x10, A → 0x08, b → 0x03, C → 0x46, d → 0x21, E → 0x06, F → 0x0E
- **Suppression:** digit k is suppressed when lzs_en = 1, its value = 0, and every digit j > k is 0 or blanked.
  - Digit 0 is never suppressed.
  - A suppressed digit shows seg = 7'h7F, but its dp still follows dp_in.
- **Blank:** `blank_in[k]` forces seg = 7'h7F and dp = 1 for digit k. The anode is still pulsed.

## Timing
- All outputs are registered. `an`/`seg`/`dp` reflect the FSM state one cycle after the counter value that selects it.
- Reset values:
  - an = all 1s, seg = 7'h7F, dp = 1, frame_start = 0
  - slot counter = 0, index = 0, FSM = GUARD
  - shadow and active buffers = 0 (digits 0, dp off, blank off)
- First `frame_start` pulse: cycle 1 after reset deasserts. Then every NUM_DIGITS*REFRESH_CYCLES cycles.
- Load latency: at most one frame + 1 cycle from `load` to visible change.
- Reset asserted mid-scan: the next edge returns everything to reset values. No partial slot continues.
- Counter widths: $clog2(REFRESH_CYCLES) and max(1, $clog2(NUM_DIGITS)).
- No arithmetic overflow is possible; wraps are explicit compares, not power-of-two rollover.

## Structure
- Package `seg_pkg` holds:
  - the active-low glyph constants and the 16-entry glyph table function
  - SEG_OFF = 7'h7F
  - the FSM state typedef {GUARD, SHOW}
- One sub-module, `hex_glyph`: combinational 4-bit → 7-bit active-low decoder using the package table. Instantiated once, on the muxed active digit, not per digit.
- Top level contains the buffers, counters, FSM, suppression logic and output registers.

## Test plan
- **Reset:** NUM_DIGITS=4, REFRESH_CYCLES=8, GUARD_CYCLES=2; hold reset 3 cycles → an=4'hF, seg=7'h7F, dp=1 throughout; frame_start pulses 1 cycle after release.
- **Scan order:** load digits_in=16'h1234, dp_in=0, blank_in=0 → per slot, 2 cycles dark, then 6 cycles of:
  - an=4'hE with seg=0x19 (digit 0)
  - an=4'hD with 0x30
  - an=4'hB with 0x24
  - an=4'h7 with 0x79
  - frame_start period = 32 cycles
- **Glyphs:** NUM_DIGITS=1, sweep values 0..F via load → seg matches the table above for all 16 values.
- **Double buffering:** load 16'hAAAA, then at cycle 10 of the frame load 16'h5555 → remainder of the frame shows A (0x08); the next frame shows 5 (0x12).
- **LZS and blank:**
  - lzs_en=1, digits_in=16'h0050, dp_in=4'b0100 → digit 3 dark, digit 2 dark seg with dp=0, digits 1/0 show 5/0.
  - blank_in=4'b0001 → digit 0 fully dark.
- **Reset mid-scan:** assert reset during the digit 2 SHOW → the next cycle returns to reset values; after release the scan restarts at digit 0 with buffers cleared (all digits show 0x40).
